// File: rtl/rw_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// rw_mem_access_ctrl
//
// Request sequencer sitting directly in front of the 96x8 synchronous RW
// memory (0x80-0xDF). One load or store is in flight at a time. The memory
// address, write enable and write data are driven from registers, and the
// memory's one-cycle registered read latency is absorbed by a CAPTURE state.
// Requests outside [BASE_ADDR, TOP_ADDR] are answered with an error response
// and never reach the memory.
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both 1. The source holds its payload stable while
// valid=1 and ready=0. req_ready is 1 only in IDLE; rsp_valid is 1 only in
// RESP, so a response and a new request never transfer on the same edge.
//
// Ports
//   clk          in   1    rising-edge clock, shared with the RW memory
//   reset        in   1    asynchronous, active-low reset
//   req_valid    in   1    request present
//   req_ready    out  1    controller can accept (IDLE only)
//   req_we       in   1    1=store, 0=load
//   req_addr     in   AW   byte address
//   req_wdata    in   DW   store data
//   rsp_valid    out  1    response present
//   rsp_ready    in   1    consumer takes response
//   rsp_rdata    out  DW   load data (0 for stores and errors)
//   rsp_err      out  1    request address was outside the RW window
//   err_count    out  8    saturating count of rejected requests
//   mem_address  out  AW   registered memory address
//   mem_WE       out  1    registered memory write enable
//   mem_data_in  out  DW   registered memory write data
//   mem_data_out in   DW   memory read data (valid one edge after the read)
//   state_dbg    out  2    current FSM state (IDLE=0, ACCESS=1, CAPTURE=2, RESP=3)
// -----------------------------------------------------------------------------
module rw_mem_access_ctrl #(
   parameter int          ADDR_WIDTH = 8,
   parameter int          DATA_WIDTH = 8,
   parameter int unsigned BASE_ADDR  = 128,
   parameter int unsigned TOP_ADDR   = 223
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic [7:0]            err_count,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_WE,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   input  logic [DATA_WIDTH-1:0] mem_data_out,
   output logic [1:0]            state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACCESS  = 2'd1,
      S_CAPTURE = 2'd2,
      S_RESP    = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] BASE_LIM = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] TOP_LIM  = ADDR_WIDTH'(TOP_ADDR);

   state_t state;
   state_t state_next;
   logic   in_range;

   // Unsigned compare on the full address width.
   assign in_range = (req_addr >= BASE_LIM) && (req_addr <= TOP_LIM);

   assign req_ready = (state == S_IDLE);
   assign rsp_valid = (state == S_RESP);
   assign state_dbg = state;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               state_next = in_range ? S_ACCESS : S_RESP;
            end
         end
         // mem_WE still holds the latched req_we here, so it tells store from load.
         S_ACCESS:  state_next = mem_WE ? S_RESP : S_CAPTURE;
         S_CAPTURE: state_next = S_RESP;
         S_RESP: begin
            if (rsp_ready) begin
               state_next = S_IDLE;
            end
         end
         default:   state_next = S_IDLE;
      endcase
   end

   // Memory-side and response registers. The async reset clears mem_WE at
   // once, so a reset during ACCESS cannot cause a write at the next edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_address <= '0;
         mem_WE      <= 1'b0;
         mem_data_in <= '0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         err_count   <= 8'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  if (in_range) begin
                     mem_address <= req_addr;
                     mem_WE      <= req_we;
                     mem_data_in <= req_wdata;
                  end else begin
                     // Rejected: memory ports are left untouched.
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                     if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                     end
                  end
               end
            end
            S_ACCESS: begin
               // The memory performs the op on this edge; for a load the
               // read data appears after it, so it is captured one state later.
               if (mem_WE) begin
                  mem_WE    <= 1'b0;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= '0;
               end
            end
            S_CAPTURE: begin
               rsp_rdata <= mem_data_out;
               rsp_err   <= 1'b0;
            end
            default: begin
               // RESP: response payload held stable until taken.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rw_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rw_mem_access_ctrl
//
// Bench for rw_mem_access_ctrl. Contains a behavioural model of the 96x8
// synchronous RW memory the controller drives, a transaction-level reference
// model (expected-response queue with per-kind latency), one compare process
// that checks the controller every cycle at the falling edge, and directed
// sequences with literal expected values.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the
// falling edge.
// -----------------------------------------------------------------------------
module tb_rw_mem_access_ctrl;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_we = 1'b0;
   logic [7:0] req_addr = 8'h00;
   logic [7:0] req_wdata = 8'h00;
   logic       rsp_valid;
   logic       rsp_ready = 1'b1;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic [7:0] err_count;
   logic [7:0] mem_address;
   logic       mem_WE;
   logic [7:0] mem_data_in;
   logic [7:0] mem_data_out = 8'h00;
   logic [1:0] state_dbg;

   rw_mem_access_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .err_count    (err_count),
      .mem_address  (mem_address),
      .mem_WE       (mem_WE),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out),
      .state_dbg    (state_dbg)
   );

   // ---------------- RW memory (environment) ----------------
   logic [7:0] ram [0:95];
   logic [6:0] ram_idx;
   logic       ram_hit;
   assign ram_hit = (mem_address >= 8'h80) && (mem_address <= 8'hDF);
   assign ram_idx = 7'(mem_address - 8'h80);

   always @(posedge clk) begin
      if (mem_WE && ram_hit) ram[ram_idx] <= mem_data_in;
      mem_data_out <= ram_hit ? ram[ram_idx] : 8'h00;
   end

   // ---------------- counters / check ----------------
   int n_tests = 0;
   int n_fail  = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- reference model ----------------
   logic [7:0] model_mem [0:255];
   logic [7:0] exp_q[$];      // expected rsp_rdata
   logic       err_q[$];
   logic       we_q[$];
   logic [7:0] addr_q[$];
   logic [7:0] wd_q[$];
   int         acc_q[$];      // cycle index of the accepting falling edge
   int         lat_q[$];      // cycles from accept to rsp_valid
   int         model_err = 0;
   int         cyc = 0;
   int         n_rsp = 0;

   // Compare process: one pass per falling edge.
   always @(negedge clk) begin
      logic exp_valid;
      logic exp_we;
      logic in_win;
      if (!reset) begin
         exp_q.delete(); err_q.delete(); we_q.delete(); addr_q.delete();
         wd_q.delete(); acc_q.delete(); lat_q.delete();
         model_err = 0;
         check("rst_rsp_valid", rsp_valid, 0);
         check("rst_mem_we", mem_WE, 0);
         check("rst_err_count", err_count, 0);
         check("rst_mem_address", mem_address, 0);
         check("rst_rsp_err", rsp_err, 0);
         check("rst_rsp_rdata", rsp_rdata, 0);
      end else begin
         exp_valid = (exp_q.size() > 0) && ((cyc - acc_q[0]) >= lat_q[0]);
         exp_we    = (exp_q.size() > 0) && we_q[0] && !err_q[0] && ((cyc - acc_q[0]) == 1);
         check("rsp_valid", rsp_valid, exp_valid);
         check("req_ready", req_ready, exp_q.size() == 0);
         check("mem_we", mem_WE, exp_we);
         check("err_count", err_count, model_err);
         if (exp_we) begin
            check("mem_address", mem_address, addr_q[0]);
            check("mem_data_in", mem_data_in, wd_q[0]);
         end
         if (exp_valid && rsp_valid) begin
            check("rsp_rdata", rsp_rdata, exp_q[0]);
            check("rsp_err", rsp_err, err_q[0]);
         end
         // Response taken at the coming edge.
         if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
            if (we_q[0] && !err_q[0]) model_mem[addr_q[0]] = wd_q[0];
            n_rsp++;
            void'(exp_q.pop_front()); void'(err_q.pop_front()); void'(we_q.pop_front());
            void'(addr_q.pop_front()); void'(wd_q.pop_front());
            void'(acc_q.pop_front()); void'(lat_q.pop_front());
         end
         // Request accepted at the coming edge.
         if (req_valid && req_ready) begin
            in_win = (req_addr >= 8'h80) && (req_addr <= 8'hDF);
            err_q.push_back(!in_win);
            we_q.push_back(req_we);
            addr_q.push_back(req_addr);
            wd_q.push_back(req_wdata);
            acc_q.push_back(cyc);
            if (!in_win) begin
               exp_q.push_back(8'h00);
               lat_q.push_back(1);
               if (model_err < 255) model_err++;
            end else if (req_we) begin
               exp_q.push_back(8'h00);
               lat_q.push_back(2);
            end else begin
               exp_q.push_back(model_mem[req_addr]);
               lat_q.push_back(3);
            end
         end
      end
      cyc++;
   end

   // ---------------- driver tasks ----------------
   // One request with rsp_ready=1; returns the response and its latency in
   // cycles counted from the accepting edge.
   task automatic do_req(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                         output logic [7:0] rdata, output logic err, output int lat);
      logic acc;
      logic got;
      acc = 1'b0; got = 1'b0; lat = 0; rdata = 8'hxx; err = 1'bx;
      rsp_ready = 1'b1;
      req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      for (int k = 0; k < 50 && !acc; k++) begin
         @(negedge clk); acc = req_ready;
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      if (!acc) check("accept_timeout", 0, 1);
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk); lat++;
         if (rsp_valid) begin
            rdata = rsp_rdata; err = rsp_err; got = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (!got) check("response_timeout", 0, 1);
   endtask

   // Requests held back-to-back with req_valid=1 throughout.
   task automatic stream(input int n, input logic [7:0] addrs[6], input logic wes[6],
                         input logic [7:0] wds[6]);
      logic acc;
      rsp_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         req_we = wes[i]; req_addr = addrs[i]; req_wdata = wds[i]; req_valid = 1'b1;
         acc = 1'b0;
         for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk); acc = req_ready;
            @(posedge clk); #1;
         end
         if (!acc) check("stream_accept_timeout", 0, 1);
      end
      req_valid = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
   endtask

   // ---------------- directed sequences ----------------
   initial begin
      logic [7:0] rd;
      logic       er;
      int         lat;
      int         rsp_start;
      logic [7:0] s_addr [6];
      logic       s_we   [6];
      logic [7:0] s_wd   [6];
      logic [7:0] bad    [4];

      for (int i = 0; i < 96; i++) ram[i] = 8'h00;
      for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
      ram[7'h10] = 8'h11;          // preload 0x90
      model_mem[8'h90] = 8'h11;

      // Reset
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("idle_req_ready", req_ready, 1);
      @(posedge clk); #1;

      // Store/load at the low boundary
      do_req(1'b1, 8'h80, 8'hA5, rd, er, lat);
      check("st80_err", er, 0);
      check("st80_lat", lat, 2);
      do_req(1'b0, 8'h80, 8'h00, rd, er, lat);
      check("ld80_rdata", rd, 8'hA5);
      check("ld80_err", er, 0);
      check("ld80_lat", lat, 3);

      // High boundary and just-outside addresses
      do_req(1'b1, 8'hDF, 8'h3C, rd, er, lat);
      do_req(1'b0, 8'hDF, 8'h00, rd, er, lat);
      check("ldDF_rdata", rd, 8'h3C);
      do_req(1'b0, 8'h7F, 8'h00, rd, er, lat);
      check("ld7F_err", er, 1);
      check("ld7F_rdata", rd, 8'h00);
      check("ld7F_lat", lat, 1);
      do_req(1'b0, 8'hE0, 8'h00, rd, er, lat);
      check("ldE0_err", er, 1);
      check("ldE0_rdata", rd, 8'h00);
      do_req(1'b1, 8'hE0, 8'hEE, rd, er, lat);
      check("stE0_err", er, 1);
      @(negedge clk);
      check("err_count_3", err_count, 3);
      @(posedge clk); #1;

      // Hold rsp_ready low in RESP while another request waits
      rsp_ready = 1'b0;
      req_we = 1'b0; req_addr = 8'hDF; req_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      req_we = 1'b1; req_addr = 8'h85; req_wdata = 8'h99;   // pending, must not be taken
      for (int k = 0; k < 10 && !rsp_valid; k++) @(negedge clk);
      if (!rsp_valid) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("hold_rsp_valid", rsp_valid, 1);
         check("hold_rsp_rdata", rsp_rdata, 8'h3C);
         check("hold_req_ready", req_ready, 0);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      check("release_idle", req_ready, 1);
      @(posedge clk); #1;

      // Reset in the middle of a store's ACCESS cycle
      req_we = 1'b1; req_addr = 8'h90; req_wdata = 8'hFF; req_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      req_valid = 1'b0;
      #1;
      check("abort_we_before", mem_WE, 1);
      reset = 1'b0;
      #1;
      check("abort_we_falls", mem_WE, 0);
      check("abort_rsp_valid", rsp_valid, 0);
      @(posedge clk); #1;
      check("abort_ram_untouched", ram[7'h10], 8'h11);
      @(posedge clk); #1;
      reset = 1'b1;
      do_req(1'b0, 8'h90, 8'h00, rd, er, lat);
      check("abort_ld90", rd, 8'h11);

      // Back-to-back requests, order preserved
      s_addr = '{8'hA0, 8'hA0, 8'h00, 8'hC3, 8'hC3, 8'hDF};
      s_we   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      s_wd   = '{8'h5A, 8'h00, 8'h00, 8'h77, 8'h00, 8'h00};
      rsp_start = n_rsp;
      stream(6, s_addr, s_we, s_wd);
      check("stream_responses", n_rsp - rsp_start, 6);
      check("stream_drained", exp_q.size(), 0);
      @(posedge clk); #1;
      do_req(1'b0, 8'hC3, 8'h00, rd, er, lat);
      check("stream_ldC3", rd, 8'h77);

      // err_count saturation
      bad = '{8'h7F, 8'hE0, 8'h00, 8'hFF};
      for (int i = 0; i < 260; i++) begin
         do_req(i[0], bad[i % 4], 8'h42, rd, er, lat);
      end
      @(negedge clk);
      check("err_count_sat", err_count, 255);
      @(posedge clk); #1;

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Watchdog
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

endmodule
